// File: rtl/read_burst_pkg.sv
// Shared definitions for the FIFO read-burst controller: FSM encoding,
// gear codes and the gear -> {burst length, channel} table.
package read_burst_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_BURST = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] GEAR_52 = 8'h52;
    localparam logic [7:0] GEAR_51 = 8'h51;
    localparam logic [7:0] GEAR_4F = 8'h4F;
    localparam logic [7:0] GEAR_4E = 8'h4E;
    localparam logic [7:0] GEAR_4D = 8'h4D;
    localparam logic [7:0] GEAR_4C = 8'h4C;
    localparam logic [7:0] GEAR_4B = 8'h4B;
    localparam logic [7:0] GEAR_4A = 8'h4A;
    localparam logic [7:0] GEAR_49 = 8'h49;
    localparam logic [7:0] GEAR_48 = 8'h48;
    localparam logic [7:0] GEAR_47 = 8'h47;
    localparam logic [7:0] GEAR_46 = 8'h46;
    localparam logic [7:0] GEAR_45 = 8'h45;
    localparam logic [7:0] GEAR_44 = 8'h44;
    localparam logic [7:0] GEAR_43 = 8'h43;
    localparam logic [7:0] GEAR_42 = 8'h42;
    localparam logic [7:0] GEAR_41 = 8'h41;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             ch;
    } gear_cfg_t;

    // Unknown codes return len 0, which the controller treats as "do not start".
    function automatic gear_cfg_t gear_lookup(input logic [7:0] code);
        gear_cfg_t cfg;
        cfg.len = '0;
        cfg.ch  = 1'b0;
        case (code)
            GEAR_52:                         cfg.len = 16'd48;
            GEAR_51:                         cfg.len = 16'd20;
            GEAR_4F, GEAR_4E:                cfg.len = 16'd40;
            GEAR_4D, GEAR_4C:                cfg.len = 16'd80;
            GEAR_4B, GEAR_4A:                cfg.len = 16'd160;
            GEAR_49:                         cfg.len = 16'd320;
            GEAR_48, GEAR_47, GEAR_46,
            GEAR_45, GEAR_44:                cfg.len = 16'd160;
            GEAR_43: begin
                cfg.len = 16'd320;
                cfg.ch  = 1'b1;
            end
            GEAR_42: begin
                cfg.len = 16'd480;
                cfg.ch  = 1'b1;
            end
            GEAR_41:                         cfg.len = 16'd480;
            default:                         cfg.len = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/gear_sync_det.sv
// Two-flop synchroniser for the asynchronous gear code, change detect,
// and the one-cycle active-low reset pulse sent to the downstream P2S.
module gear_sync_det #(
    parameter int GEAR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [GEAR_W-1:0] gear_i,
    output logic [GEAR_W-1:0] g2_o,
    output logic              gear_chg_o,
    output logic              p2s_rstn_o
);

    logic [GEAR_W-1:0] g1_q;
    logic [GEAR_W-1:0] g2_q;
    logic              rstn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g1_q   <= '0;
            g2_q   <= '0;
            rstn_q <= 1'b1;
        end else begin
            g1_q   <= gear_i;
            g2_q   <= g1_q;
            rstn_q <= (g1_q == g2_q);
        end
    end

    assign g2_o       = g2_q;
    assign gear_chg_o = (g1_q != g2_q);
    assign p2s_rstn_o = rstn_q | rst_i;

endmodule

// File: rtl/read_burst_ctrl.sv
// Issues exactly r_len FIFO reads on the channel selected by the gear code,
// aborting on a gear change and giving up after too many empty cycles.
module read_burst_ctrl
    import read_burst_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int GEAR_W    = 8,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 64
) (
    input  logic              i_clk100m,
    input  logic              i_rst,
    input  logic [GEAR_W-1:0] i_down_gear,
    input  logic [NUM_CH-1:0] i_rd_flag,
    input  logic [NUM_CH-1:0] i_fifo_empty,
    output logic [NUM_CH-1:0] o_rd_en,
    output logic              o_p2s_rstn,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_abort,
    output logic              o_underrun
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    logic [GEAR_W-1:0]  g2;
    logic               gear_chg;
    logic [31:0]        gear_ext;
    gear_cfg_t          cfg;
    logic               gear_valid;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
    logic               underrun_q, underrun_d;

    logic               rd_fire;
    logic [CNT_W-1:0]   count_inc;
    logic [STALL_W-1:0] stall_inc;

    gear_sync_det #(
        .GEAR_W (GEAR_W)
    ) u_gear_sync (
        .clk_i      (i_clk100m),
        .rst_i      (i_rst),
        .gear_i     (i_down_gear),
        .g2_o       (g2),
        .gear_chg_o (gear_chg),
        .p2s_rstn_o (o_p2s_rstn)
    );

    // Codes wider than 8 bits are only valid when the upper bits are zero.
    assign gear_ext   = 32'(g2);
    assign cfg        = gear_lookup(gear_ext[7:0]);
    assign gear_valid = (g2 != '0) && (gear_ext[31:8] == 24'd0) && (cfg.len != '0);

    // The read strobe is combinational so an empty FIFO, a gear change or
    // reset suppresses it in the very cycle it is seen.
    assign rd_fire   = (state_q == ST_BURST) && !gear_chg && !i_rst && !i_fifo_empty[ch_q];
    assign count_inc = count_q + CNT_W'(1);
    assign stall_inc = stall_q + STALL_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rd_en
            assign o_rd_en[gi] = rd_fire && (ch_q == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ch_d       = ch_q;
        count_d    = count_q;
        stall_d    = stall_q;
        abort_d    = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gear_valid) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!gear_chg && gear_valid) begin
                    len_d   = CNT_W'(cfg.len);
                    ch_d    = CH_W'(cfg.ch);
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (gear_chg) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_rd_flag[ch_q]) begin
                    count_d = '0;
                    stall_d = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (gear_chg) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (rd_fire) begin
                    count_d = count_inc;
                    stall_d = '0;
                    if (count_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == STALL_W'(STALL_MAX)) begin
                        underrun_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk100m) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ch_q       <= '0;
            count_q    <= '0;
            stall_q    <= '0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ch_q       <= ch_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            abort_q    <= abort_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_busy     = !i_rst && ((state_q == ST_ARM) || (state_q == ST_BURST));
    assign o_done     = !i_rst && (state_q == ST_DONE);
    assign o_abort    = !i_rst && abort_q;
    assign o_underrun = !i_rst && underrun_q;

endmodule
